ps2_key_matrix: RTL

Converts a PS/2 scan-code set 2 byte stream into the 8x5 ZX Spectrum keyboard matrix. It drives the active-low `kd[4:0]` column lines that the I/O port block reads on port #FE.
It sits between the PS/2 receiver and the port block. Row selection uses CPU address lines A15..A8.
It also produces the Magic (NMI) and reset requests that come from hotkeys.

---
 rtl/ps2_key_matrix.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_matrix.sv
// PS/2 scan-code set 2 decoder driving the ZX Spectrum 8x5 keyboard matrix,
// plus the Magic (NMI) and Ctrl+Alt+Del reset hotkeys.
module ps2_key_matrix #(
   parameter int PREFIX_TIMEOUT = 2800000,
   parameter int PAUSE_SKIP     = 7
) (
   input  logic       clk28,
   input  logic       rst,
   input  logic       scan_valid,
   input  logic [7:0] scan_code,
   input  logic [7:0] addr_hi,
   output logic [4:0] kd,
   output logic       magic_button,
   output logic       reset_button,
   output logic       key_any
);

   typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

   localparam int TO_W   = $clog2(PREFIX_TIMEOUT + 1);
   localparam int SKIP_W = $clog2(PAUSE_SKIP + 1);
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(PREFIX_TIMEOUT - 1);
   localparam logic [SKIP_W-1:0] SKIP_ONE = SKIP_W'(1);

   // Held-source indices: 0..39 are matrix keys (row*5+col), the rest are
   // keys that reach the matrix only through composites or hotkeys.
   localparam int NSRC      = 48;
   localparam int SRC_LCTRL = 40;
   localparam int SRC_LALT  = 41;
   localparam int SRC_DEL   = 42;
   localparam int SRC_BKSP  = 43;
   localparam int SRC_LEFT  = 44;
   localparam int SRC_DOWN  = 45;
   localparam int SRC_UP    = 46;
   localparam int SRC_RIGHT = 47;

   state_t            state_q, next_state;
   logic [TO_W-1:0]   to_cnt;
   logic [SKIP_W-1:0] skip_cnt;
   logic [NSRC-1:0]   held_q, held_n;
   logic [39:0]       pressed;
   logic [6:0]        src;
   logic [4:0]        col_and;
   logic              is_clear, in_prefix, make_ev, brk_ev, ext_ev;

   // Returns {hit, source index}; extended codes never fall back to the base table.
   function automatic logic [6:0] src_map(input logic ext, input logic [7:0] code);
      logic [6:0] r;
      r = '0;
      if (ext) begin
         case (code)
            8'h71: r = {1'b1, 6'(SRC_DEL)};
            8'h6B: r = {1'b1, 6'(SRC_LEFT)};
            8'h72: r = {1'b1, 6'(SRC_DOWN)};
            8'h75: r = {1'b1, 6'(SRC_UP)};
            8'h74: r = {1'b1, 6'(SRC_RIGHT)};
            default: r = '0;
         endcase
      end else begin
         case (code)
            8'h12: r = {1'b1, 6'd0};   8'h1A: r = {1'b1, 6'd1};
            8'h22: r = {1'b1, 6'd2};   8'h21: r = {1'b1, 6'd3};
            8'h2A: r = {1'b1, 6'd4};   8'h1C: r = {1'b1, 6'd5};
            8'h1B: r = {1'b1, 6'd6};   8'h23: r = {1'b1, 6'd7};
            8'h2B: r = {1'b1, 6'd8};   8'h34: r = {1'b1, 6'd9};
            8'h15: r = {1'b1, 6'd10};  8'h1D: r = {1'b1, 6'd11};
            8'h24: r = {1'b1, 6'd12};  8'h2D: r = {1'b1, 6'd13};
            8'h2C: r = {1'b1, 6'd14};  8'h16: r = {1'b1, 6'd15};
            8'h1E: r = {1'b1, 6'd16};  8'h26: r = {1'b1, 6'd17};
            8'h25: r = {1'b1, 6'd18};  8'h2E: r = {1'b1, 6'd19};
            8'h45: r = {1'b1, 6'd20};  8'h46: r = {1'b1, 6'd21};
            8'h3E: r = {1'b1, 6'd22};  8'h3D: r = {1'b1, 6'd23};
            8'h36: r = {1'b1, 6'd24};  8'h4D: r = {1'b1, 6'd25};
            8'h44: r = {1'b1, 6'd26};  8'h43: r = {1'b1, 6'd27};
            8'h3C: r = {1'b1, 6'd28};  8'h35: r = {1'b1, 6'd29};
            8'h5A: r = {1'b1, 6'd30};  8'h4B: r = {1'b1, 6'd31};
            8'h42: r = {1'b1, 6'd32};  8'h3B: r = {1'b1, 6'd33};
            8'h33: r = {1'b1, 6'd34};  8'h29: r = {1'b1, 6'd35};
            8'h59: r = {1'b1, 6'd36};  8'h3A: r = {1'b1, 6'd37};
            8'h31: r = {1'b1, 6'd38};  8'h32: r = {1'b1, 6'd39};
            8'h14: r = {1'b1, 6'(SRC_LCTRL)};
            8'h11: r = {1'b1, 6'(SRC_LALT)};
            8'h66: r = {1'b1, 6'(SRC_BKSP)};
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   // A matrix bit is the OR of every held source that drives it.
   function automatic logic [39:0] pressed_of(input logic [NSRC-1:0] h);
      logic [39:0] p;
      p      = h[39:0];
      p[36] |= h[SRC_LCTRL];
      p[0]  |= h[SRC_BKSP] | h[SRC_LEFT] | h[SRC_DOWN] | h[SRC_UP] | h[SRC_RIGHT];
      p[20] |= h[SRC_BKSP];
      p[19] |= h[SRC_LEFT];
      p[24] |= h[SRC_DOWN];
      p[23] |= h[SRC_UP];
      p[22] |= h[SRC_RIGHT];
      return p;
   endfunction

   assign is_clear  = (scan_code == 8'hAA) || (scan_code == 8'hFC) ||
                      (scan_code == 8'h00) || (scan_code == 8'hFF);
   assign in_prefix = (state_q == S_EXT) || (state_q == S_BRK) || (state_q == S_EXT_BRK);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk28) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= next_state;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state_q;
      if (scan_valid) begin
         if (is_clear) begin
            next_state = S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if      (scan_code == 8'hE0) next_state = S_EXT;
                  else if (scan_code == 8'hF0) next_state = S_BRK;
                  else if (scan_code == 8'hE1) next_state = S_SKIP;
               end
               S_EXT:   next_state = (scan_code == 8'hF0) ? S_EXT_BRK : S_IDLE;
               S_SKIP:  if (skip_cnt == SKIP_ONE) next_state = S_IDLE;
               default: next_state = S_IDLE;
            endcase
         end
      end else if (in_prefix && to_cnt == TO_LAST) begin
         next_state = S_IDLE;
      end
   end

   always_comb begin
      make_ev = 1'b0;
      brk_ev  = 1'b0;
      ext_ev  = (state_q == S_EXT) || (state_q == S_EXT_BRK);
      if (scan_valid && !is_clear) begin
         case (state_q)
            S_IDLE:  make_ev = (scan_code != 8'hE0) && (scan_code != 8'hF0) &&
                               (scan_code != 8'hE1);
            S_EXT:   make_ev = (scan_code != 8'hF0);
            S_BRK, S_EXT_BRK: brk_ev = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk28) begin
      if (rst) begin
         to_cnt   <= '0;
         skip_cnt <= '0;
      end else begin
         if (scan_valid || !in_prefix || to_cnt == TO_LAST) to_cnt <= '0;
         else                                              to_cnt <= to_cnt + 1'b1;
         if (scan_valid) begin
            if (is_clear)
               skip_cnt <= '0;
            else if (state_q == S_IDLE && scan_code == 8'hE1)
               skip_cnt <= SKIP_W'(PAUSE_SKIP);
            else if (state_q == S_SKIP)
               skip_cnt <= skip_cnt - 1'b1;
         end
      end
   end

   always_comb begin
      held_n = held_q;
      src    = src_map(ext_ev, scan_code);
      if (scan_valid && is_clear) held_n = '0;
      else if (src[6] && make_ev) held_n[src[5:0]] = 1'b1;
      else if (src[6] && brk_ev)  held_n[src[5:0]] = 1'b0;
   end

   assign pressed = pressed_of(held_q);
   assign key_any = |pressed;

   always_comb begin
      col_and = 5'b11111;
      for (int r = 0; r < 8; r++)
         if (!addr_hi[r]) col_and &= ~pressed[r*5 +: 5];
   end

   always_ff @(posedge clk28) begin
      if (rst) begin
         held_q       <= '0;
         kd           <= 5'b11111;
         magic_button <= 1'b0;
         reset_button <= 1'b0;
      end else begin
         held_q       <= held_n;
         kd           <= col_and;
         magic_button <= make_ev && !ext_ev && (scan_code == 8'h07);
         reset_button <= held_n[SRC_LCTRL] & held_n[SRC_LALT] & held_n[SRC_DEL];
      end
   end

endmodule
